ntr_resp_tx: RTL and testbench

- Transmit side of the NTR cartridge bus. The command receiver in top captures the 8-byte command; this block then drives response bytes back to the host on ntr_data.
- Runs in the system clk domain and oversamples the async ntr_clk/ntr_cs1.
- Pulls payload from an upstream byte stream (ROM/FIFO) over a valid/ready handshake.
- Bytes change after falling ntr_clk so the host samples stable data on rising ntr_clk.

---
 rtl/ntr_pkg.sv | 27 ++
 rtl/ntr_edge_sync.sv | 25 ++
 rtl/ntr_resp_tx.sv | 148 ++++++++++++++
 tb/tb_ntr_resp_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntr_pkg.sv
// Shared NTR bus definitions: transmit FSM encoding, fill byte and CRC16-CCITT helpers.
package ntr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } ntr_state_e;

  localparam logic [7:0]  FILL_BYTE_DEF = 8'hFF;
  localparam logic [15:0] CRC_POLY      = 16'h1021;
  localparam logic [15:0] CRC_INIT      = 16'hFFFF;

  // Advance a CRC16-CCITT by one byte, MSB first.
  function automatic logic [15:0] crc16_step8(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/ntr_edge_sync.sv
// Two-flop synchronizer plus an edge-detect flop for one asynchronous bus input.
module ntr_edge_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [2:0] r_sh;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sh <= {3{RESET_VAL}};
    else        r_sh <= {r_sh[1:0], i_async};
  end

  assign o_sync = r_sh[1];
  assign o_rise = r_sh[1] & ~r_sh[2];
  assign o_fall = ~r_sh[1] & r_sh[2];

endmodule

// File: rtl/ntr_resp_tx.sv
// NTR cartridge response transmitter: drives gap, payload and (with NTR_TX_CRC_EN) a CRC16 trailer
// onto ntr_data, one byte per falling ntr_clk, oversampled in the system clk domain.
module ntr_resp_tx
  import ntr_pkg::*;
#(
  parameter int         LEN_W     = 15,
  parameter int         GAP_CLKS  = 1,
  parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ntr_clk,
  input  logic             ntr_cs1,
  input  logic             cmd_done,
  input  logic [LEN_W-1:0] resp_len,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       ntr_dout,
  output logic             ntr_oe,
  output logic             busy,
  output logic             underrun
);

  localparam int GAP_W = $clog2(GAP_CLKS + 2);

  ntr_state_e       r_state, w_state_nxt;
  logic [LEN_W-1:0] r_rem;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [7:0]       r_dout;
  logic             r_tx_ready, r_underrun;
  logic             w_clk_lvl, w_clk_rise, w_clk_fall;
  logic             w_cs1_lvl, w_cs1_rise, w_cs1_fall;
  logic             w_accept, w_byte_due, w_tail;
`ifdef NTR_TX_CRC_EN
  logic [15:0]      r_crc;
  logic [1:0]       r_crc_phase;
`endif

  ntr_edge_sync #(.RESET_VAL(1'b0)) u_clk_sync (
    .clk(clk), .rst_n(rst_n), .i_async(ntr_clk),
    .o_sync(w_clk_lvl), .o_rise(w_clk_rise), .o_fall(w_clk_fall)
  );

  ntr_edge_sync #(.RESET_VAL(1'b1)) u_cs1_sync (
    .clk(clk), .rst_n(rst_n), .i_async(ntr_cs1),
    .o_sync(w_cs1_lvl), .o_rise(w_cs1_rise), .o_fall(w_cs1_fall)
  );

  // A chip-select release outranks a coincident cmd_done.
  assign w_accept   = (r_state == ST_IDLE) && cmd_done && !w_cs1_lvl && !w_cs1_rise;
  assign w_byte_due = (r_state == ST_SEND) && w_clk_fall && (r_rem != '0);
  assign w_tail     = (r_state == ST_SEND) && w_clk_fall && (r_rem == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: always_comb assigns a default first so no path leaves w_state_nxt unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    if (w_cs1_rise) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          if (resp_len == '0)    w_state_nxt = ST_DONE;
          else if (GAP_CLKS == 0) w_state_nxt = ST_SEND;
          else                    w_state_nxt = ST_GAP;
        end
        ST_GAP:  if (w_clk_fall && (r_gap_cnt <= GAP_W'(1))) w_state_nxt = ST_SEND;
`ifdef NTR_TX_CRC_EN
        ST_SEND: if (w_tail && (r_crc_phase == 2'd2)) w_state_nxt = ST_DONE;
`else
        ST_SEND: if (w_tail) w_state_nxt = ST_DONE;
`endif
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem       <= '0;
      r_gap_cnt   <= '0;
      r_dout      <= FILL_BYTE;
      r_tx_ready  <= 1'b0;
      r_underrun  <= 1'b0;
`ifdef NTR_TX_CRC_EN
      r_crc       <= CRC_INIT;
      r_crc_phase <= 2'd0;
`endif
    end else begin
      r_tx_ready <= 1'b0;
      if (w_accept) begin
        r_rem       <= resp_len;
        r_gap_cnt   <= GAP_W'(GAP_CLKS);
        r_dout      <= FILL_BYTE;
        r_underrun  <= 1'b0;
`ifdef NTR_TX_CRC_EN
        r_crc       <= CRC_INIT;
        r_crc_phase <= 2'd0;
`endif
      end else if (!w_cs1_rise) begin
        if ((r_state == ST_GAP) && w_clk_fall) r_gap_cnt <= r_gap_cnt - GAP_W'(1);
        if (w_byte_due) begin
          r_rem <= r_rem - LEN_W'(1);
          if (tx_valid) begin
            r_dout     <= tx_data;
            r_tx_ready <= 1'b1;
`ifdef NTR_TX_CRC_EN
            r_crc      <= crc16_step8(r_crc, tx_data);
`endif
          end else begin
            // Missing data still consumes a slot so the host sees the promised length.
            r_dout     <= FILL_BYTE;
            r_underrun <= 1'b1;
`ifdef NTR_TX_CRC_EN
            r_crc      <= crc16_step8(r_crc, FILL_BYTE);
`endif
          end
        end
`ifdef NTR_TX_CRC_EN
        if (w_tail) begin
          case (r_crc_phase)
            2'd0:    begin r_dout <= r_crc[15:8]; r_crc_phase <= 2'd1; end
            2'd1:    begin r_dout <= r_crc[7:0];  r_crc_phase <= 2'd2; end
            default: r_crc_phase <= r_crc_phase;
          endcase
        end
`endif
      end
    end
  end

  assign tx_ready = r_tx_ready;
  assign ntr_dout = r_dout;
  assign ntr_oe   = (r_state == ST_GAP) || (r_state == ST_SEND);
  assign busy     = (r_state != ST_IDLE);
  assign underrun = r_underrun;

  a_clk_edges: assert property (@(posedge clk) disable iff (!rst_n)
    w_clk_rise |-> (w_clk_lvl && !w_clk_fall));
  a_cs1_edges: assert property (@(posedge clk) disable iff (!rst_n)
    w_cs1_fall |-> !w_cs1_lvl);

endmodule

// File: tb/tb_ntr_resp_tx.sv
// Scoreboard bench for ntr_resp_tx: a host model toggles ntr_clk, a monitor compares bytes at rising ntr_clk.
module tb_ntr_resp_tx;

  localparam int         LEN_W    = 15;
  localparam int         GAP_CLKS = 1;
  localparam logic [7:0] FILL     = 8'hFF;
`ifdef NTR_TX_CRC_EN
  localparam int         CRC_BYTES = 2;
`else
  localparam int         CRC_BYTES = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ntr_clk = 1'b1;
  logic             ntr_cs1 = 1'b1;
  logic             cmd_done = 1'b0;
  logic [LEN_W-1:0] resp_len = '0;
  logic [7:0]       tx_data = 8'h00;
  logic             tx_valid = 1'b0;
  logic             tx_ready;
  logic [7:0]       ntr_dout;
  logic             ntr_oe;
  logic             busy;
  logic             underrun;

  ntr_resp_tx dut (
    .clk(clk), .rst_n(rst_n), .ntr_clk(ntr_clk), .ntr_cs1(ntr_cs1),
    .cmd_done(cmd_done), .resp_len(resp_len), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .ntr_dout(ntr_dout), .ntr_oe(ntr_oe), .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int         chk_cnt = 0;
  int         pass_cnt = 0;
  int         ready_cnt = 0;
  int         oe_cycles = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mdl_q[$];
  logic [7:0] slot_data[$];
  logic       slot_valid[$];
  int         exp_ready;
  logic       exp_und;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Host-side monitor: every byte the host latches with the pad enabled must be the next expected one.
  always @(posedge ntr_clk) begin
    if (rst_n && ntr_oe) begin
      if (exp_q.size() == 0) check("stray_oe_byte", {31'd0, ntr_oe}, 32'd0);
      else check("host_byte", {24'd0, ntr_dout}, {24'd0, exp_q.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (tx_ready) ready_cnt++;
    if (ntr_oe)   oe_cycles++;
  end

  function automatic logic [15:0] crc16(input logic [7:0] b[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (b[i]) begin
      c = c ^ {b[i], 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // Reference model: gap fill, then one slot per byte (fill when withheld), then optional CRC.
  task automatic model();
    logic [7:0]  drv[$];
    logic [15:0] c;
    mdl_q.delete();
    exp_ready = 0;
    exp_und   = 1'b0;
    for (int g = 0; g < GAP_CLKS; g++) mdl_q.push_back(FILL);
    foreach (slot_data[i]) begin
      drv.push_back(slot_valid[i] ? slot_data[i] : FILL);
      if (slot_valid[i]) exp_ready++;
      else exp_und = 1'b1;
    end
    foreach (drv[i]) mdl_q.push_back(drv[i]);
    if (CRC_BYTES > 0) begin
      c = crc16(drv);
      mdl_q.push_back(c[15:8]);
      mdl_q.push_back(c[7:0]);
    end
  endtask

  task automatic fill_random(input int len, input int pct);
    slot_data.delete();
    slot_valid.delete();
    for (int i = 0; i < len; i++) begin
      slot_data.push_back(8'($urandom));
      slot_valid.push_back($urandom_range(99) < pct);
    end
    model();
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic present(input int i);
    if (i >= 0 && i < slot_data.size()) begin
      tx_data  = slot_data[i];
      tx_valid = slot_valid[i];
    end else begin
      tx_data  = 8'h00;
      tx_valid = 1'b0;
    end
  endtask

  // Each host cycle: fall, hold, rise; the source moves to the next slot after the rise.
  task automatic ntr_cycles(input int n);
    for (int f = 1; f <= n; f++) begin
      hold($urandom_range(8, 12));
      ntr_clk = 1'b0;
      hold($urandom_range(8, 12));
      ntr_clk = 1'b1;
      present(f - GAP_CLKS);
    end
  endtask

  task automatic start(input int len);
    ntr_cs1 = 1'b0;
    hold(4);
    present(0);
    cmd_done = 1'b1;
    resp_len = LEN_W'(len);
    hold(1);
    cmd_done = 1'b0;
    hold(2);
  endtask

  task automatic release_cs();
    ntr_cs1 = 1'b1;
    hold(5);
    check("busy_after_cs_rise", {31'd0, busy}, 32'd0);
    check("oe_after_cs_rise", {31'd0, ntr_oe}, 32'd0);
  endtask

  task automatic run_xfer(input string tag);
    int r0;
    r0    = ready_cnt;
    exp_q = mdl_q;
    start(slot_data.size());
    ntr_cycles(GAP_CLKS + slot_data.size() + CRC_BYTES + 1);
    hold(5);
    check({tag, "_oe_done"}, {31'd0, ntr_oe}, 32'd0);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_ready_cnt"}, 32'(ready_cnt - r0), 32'(exp_ready));
    check({tag, "_underrun"}, {31'd0, underrun}, {31'd0, exp_und});
    release_cs();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    hold(3);
    check("rst_dout", {24'd0, ntr_dout}, {24'd0, FILL});
    check("rst_oe", {31'd0, ntr_oe}, 32'd0);
    check("rst_ready", {31'd0, tx_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    rst_n = 1'b1;
    hold(4);

    // Basic send A0..A3, all valid.
    slot_data = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    slot_valid = '{1'b1, 1'b1, 1'b1, 1'b1};
    model();
    run_xfer("basic");

    // Underrun: middle byte withheld.
    slot_data = '{8'h11, 8'h22, 8'h33};
    slot_valid = '{1'b1, 1'b0, 1'b1};
    model();
    run_xfer("underrun");

    // Zero length: pad never enabled, no pulls; also clears the previous underrun.
    slot_data.delete();
    slot_valid.delete();
    r0 = ready_cnt;
    oe_cycles = 0;
    exp_q.delete();
    start(0);
    ntr_cycles(3);
    check("zero_oe_cycles", 32'(oe_cycles), 32'd0);
    check("zero_ready", 32'(ready_cnt - r0), 32'd0);
    check("zero_busy", {31'd0, busy}, 32'd1);
    check("zero_underrun_cleared", {31'd0, underrun}, 32'd0);
    release_cs();

    // Randomized transfers.
    for (int t = 0; t < 6; t++) begin
      fill_random($urandom_range(1, 8), 80);
      run_xfer("rand");
    end

    // Abort after two of eight bytes.
    fill_random(8, 100);
    exp_q.delete();
    for (int i = 0; i < GAP_CLKS + 2; i++) exp_q.push_back(mdl_q[i]);
    r0 = ready_cnt;
    start(8);
    ntr_cycles(GAP_CLKS + 2);
    ntr_cs1 = 1'b1;
    hold(4);
    check("abort_oe", {31'd0, ntr_oe}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", 32'(ready_cnt - r0), 32'd2);
    ntr_cycles(2);
    check("abort_no_more_ready", 32'(ready_cnt - r0), 32'd2);
    check("abort_drain", 32'(exp_q.size()), 32'd0);
    fill_random(1, 100);
    run_xfer("post_abort");

    // Reset during the second payload byte, with an underrun already recorded.
    slot_data = '{8'h5A, 8'hC3, 8'h96, 8'h0F};
    slot_valid = '{1'b0, 1'b1, 1'b1, 1'b1};
    model();
    exp_q.delete();
    for (int i = 0; i < GAP_CLKS + 1; i++) exp_q.push_back(mdl_q[i]);
    start(4);
    ntr_cycles(GAP_CLKS + 1);
    check("pre_reset_underrun", {31'd0, underrun}, 32'd1);
    hold(10);
    ntr_clk = 1'b0;
    hold(5);
    rst_n = 1'b0;
    #1;
    check("midrst_dout", {24'd0, ntr_dout}, {24'd0, FILL});
    check("midrst_oe", {31'd0, ntr_oe}, 32'd0);
    check("midrst_ready", {31'd0, tx_ready}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_underrun", {31'd0, underrun}, 32'd0);
    check("midrst_drain", 32'(exp_q.size()), 32'd0);
    hold(2);
    ntr_clk = 1'b1;
    rst_n = 1'b1;
    hold(4);
    check("post_rst_idle", {31'd0, busy}, 32'd0);
    fill_random(2, 100);
    run_xfer("post_reset");

`ifdef NTR_TX_CRC_EN
    // Known-answer CRC over ASCII "123456789".
    slot_data = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    slot_valid = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    model();
    mdl_q = '{8'hFF, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
    run_xfer("crc_kat");
`endif

    hold(5);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
